// File: rtl/obj_renderer_if.sv
// ============================================================================
// Module      : obj_renderer_if
// Description : Video timing, slot configuration and pixel-result bundle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface obj_renderer_if #(
    parameter int NUM_OBJ = 4,
    parameter int IW      = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
);
    logic [9:0]         h_cnt;
    logic [9:0]         v_cnt;
    logic               pix_valid;
    logic               frame_start;
    logic               is_dark;
    logic               cfg_we;
    logic [IW-1:0]      cfg_slot;
    logic [8:0]         cfg_x;
    logic [8:0]         cfg_y;
    logic [8:0]         cfg_sx;
    logic [8:0]         cfg_sy;
    logic [8:0]         cfg_alt_sx;
    logic               cfg_en;
    logic [NUM_OBJ-1:0] collect;
    logic [16:0]        pixel_addr;
    logic               is_object;
    logic [IW-1:0]      obj_id;
    logic [NUM_OBJ-1:0] collected;

    modport master (
        output h_cnt, v_cnt, pix_valid, frame_start, is_dark,
        output cfg_we, cfg_slot, cfg_x, cfg_y, cfg_sx, cfg_sy, cfg_alt_sx, cfg_en,
        output collect,
        input  pixel_addr, is_object, obj_id, collected
    );

    modport slave (
        input  h_cnt, v_cnt, pix_valid, frame_start, is_dark,
        input  cfg_we, cfg_slot, cfg_x, cfg_y, cfg_sx, cfg_sy, cfg_alt_sx, cfg_en,
        input  collect,
        output pixel_addr, is_object, obj_id, collected
    );
endinterface

`default_nettype wire

// File: rtl/obj_renderer.sv
// ============================================================================
// Module      : obj_renderer
// Description : Multi-slot sprite overlay with pickup blink, 2-stage pipeline.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module obj_renderer #(
    parameter int NUM_OBJ      = 4,
    parameter int OBJ_W        = 10,
    parameter int OBJ_H        = 10,
    parameter int SHEET_W      = 360,
    parameter int SHEET_DEPTH  = 86400,
    parameter int BLINK_FRAMES = 16,
    parameter int IW           = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    obj_renderer_if.slave bus
);
    localparam int CW = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] C_LAST    = CW'(BLINK_FRAMES - 1);
    localparam logic [CW-1:0] C_BIT1    = CW'(2);
    localparam logic [31:0]   C_SHEET_W = 32'(SHEET_W);
    localparam logic [31:0]   C_DEPTH   = 32'(SHEET_DEPTH);

    typedef enum logic [1:0] {
        ST_HIDDEN = 2'd0,
        ST_SHOWN  = 2'd1,
        ST_BLINK  = 2'd2,
        ST_DONE   = 2'd3
    } slot_state_t;

    slot_state_t        r_state     [NUM_OBJ];
    slot_state_t        w_state_nxt [NUM_OBJ];
    logic [CW-1:0]      r_cnt       [NUM_OBJ];
    logic [CW-1:0]      w_cnt_nxt   [NUM_OBJ];
    logic [NUM_OBJ-1:0] r_collected;
    logic [NUM_OBJ-1:0] w_col_nxt;
    logic [8:0]         r_ox [NUM_OBJ];
    logic [8:0]         r_oy [NUM_OBJ];
    logic [8:0]         r_sx [NUM_OBJ];
    logic [8:0]         r_sy [NUM_OBJ];
    logic [8:0]         r_asx[NUM_OBJ];

    logic [8:0]         w_x;
    logic [8:0]         w_y;
    logic [NUM_OBJ-1:0] w_hit;
    logic [17:0]        w_dy [NUM_OBJ];
    logic [17:0]        w_dx [NUM_OBJ];
    logic [NUM_OBJ-1:0] r_hit;
    logic [17:0]        r_dy [NUM_OBJ];
    logic [17:0]        r_dx [NUM_OBJ];

    logic               w_any;
    logic [IW-1:0]      w_sel;
    logic [17:0]        w_sdy;
    logic [17:0]        w_sdx;
    logic [31:0]        w_lin;

    // Slot state transitions; a configuration write outranks everything else
    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_col_nxt[i]   = r_collected[i];
            if (bus.cfg_we && (bus.cfg_slot == IW'(i))) begin
                w_state_nxt[i] = bus.cfg_en ? ST_SHOWN : ST_HIDDEN;
                w_cnt_nxt[i]   = '0;
                w_col_nxt[i]   = 1'b0;
            end else begin
                case (r_state[i])
                    ST_SHOWN: begin
                        if (bus.collect[i]) begin
                            w_state_nxt[i] = ST_BLINK;
                            w_cnt_nxt[i]   = '0;
                        end
                    end
                    ST_BLINK: begin
                        if (bus.frame_start) begin
                            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                            if (r_cnt[i] == C_LAST) begin
                                w_state_nxt[i] = ST_DONE;
                                w_col_nxt[i]   = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_collected <= '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_state[i] <= ST_HIDDEN;
                r_cnt[i]   <= '0;
                r_ox[i]    <= '0;
                r_oy[i]    <= '0;
                r_sx[i]    <= '0;
                r_sy[i]    <= '0;
                r_asx[i]   <= '0;
            end
        end else begin
            r_collected <= w_col_nxt;
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
                if (bus.cfg_we && (bus.cfg_slot == IW'(i))) begin
                    r_ox[i]  <= bus.cfg_x;
                    r_oy[i]  <= bus.cfg_y;
                    r_sx[i]  <= bus.cfg_sx;
                    r_sy[i]  <= bus.cfg_sy;
                    r_asx[i] <= bus.cfg_alt_sx;
                end
            end
        end
    end

    assign w_x = 9'(bus.h_cnt >> 1);
    assign w_y = 9'(bus.v_cnt >> 1);

    // Stage 1: per-slot hit test (32-bit compares so ox+OBJ_W cannot wrap)
    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            w_hit[i] = bus.pix_valid
                && ((r_state[i] == ST_SHOWN)
                    || ((r_state[i] == ST_BLINK) && ((r_cnt[i] & C_BIT1) == '0)))
                && ({23'd0, w_x} >= {23'd0, r_ox[i]})
                && ({23'd0, w_x} <  ({23'd0, r_ox[i]} + 32'(OBJ_W)))
                && ({23'd0, w_y} >= {23'd0, r_oy[i]})
                && ({23'd0, w_y} <  ({23'd0, r_oy[i]} + 32'(OBJ_H)));
            w_dy[i] = {9'd0, r_sy[i]} + {9'd0, w_y} - {9'd0, r_oy[i]};
            w_dx[i] = {9'd0, (bus.is_dark ? r_asx[i] : r_sx[i])}
                    + {9'd0, w_x} - {9'd0, r_ox[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hit <= '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_dy[i] <= '0;
                r_dx[i] <= '0;
            end
        end else begin
            r_hit <= w_hit;
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_dy[i] <= w_dy[i];
                r_dx[i] <= w_dx[i];
            end
        end
    end

    // Stage 2: descending scan so the lowest hitting index is the last written
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_sdy = '0;
        w_sdx = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (r_hit[i]) begin
                w_any = 1'b1;
                w_sel = IW'(i);
                w_sdy = r_dy[i];
                w_sdx = r_dx[i];
            end
        end
        w_lin = ({14'd0, w_sdy} * C_SHEET_W) + {14'd0, w_sdx};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.is_object  <= 1'b0;
            bus.obj_id     <= '0;
            bus.pixel_addr <= '0;
        end else if (w_any) begin
            bus.is_object  <= 1'b1;
            bus.obj_id     <= w_sel;
            bus.pixel_addr <= 17'(w_lin % C_DEPTH);
        end else begin
            bus.is_object  <= 1'b0;
            bus.obj_id     <= '0;
            bus.pixel_addr <= '0;
        end
    end

    assign bus.collected = r_collected;

endmodule

`default_nettype wire

// File: tb/tb_obj_renderer.sv
// ============================================================================
// Module      : tb_obj_renderer
// Description : Directed self-checking bench for obj_renderer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_obj_renderer;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    obj_renderer_if #(.NUM_OBJ(4)) bus ();

    obj_renderer #(
        .NUM_OBJ(4), .OBJ_W(10), .OBJ_H(10), .SHEET_W(360),
        .SHEET_DEPTH(86400), .BLINK_FRAMES(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int slot, input int x, input int y, input int sx,
                       input int sy, input int asx, input logic en);
        bus.cfg_slot   = 2'(slot);
        bus.cfg_x      = 9'(x);
        bus.cfg_y      = 9'(y);
        bus.cfg_sx     = 9'(sx);
        bus.cfg_sy     = 9'(sy);
        bus.cfg_alt_sx = 9'(asx);
        bus.cfg_en     = en;
        bus.cfg_we     = 1'b1;
        tick();
        bus.cfg_we     = 1'b0;
    endtask

    // Presents a pixel and waits out the two-stage pipeline
    task automatic pix(input int h, input int v, input logic dark);
        bus.h_cnt     = 10'(h);
        bus.v_cnt     = 10'(v);
        bus.is_dark   = dark;
        bus.pix_valid = 1'b1;
        tick();
        tick();
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.h_cnt = '0; bus.v_cnt = '0; bus.pix_valid = 1'b0; bus.frame_start = 1'b0;
        bus.is_dark = 1'b0; bus.cfg_we = 1'b0; bus.cfg_slot = '0; bus.cfg_x = '0;
        bus.cfg_y = '0; bus.cfg_sx = '0; bus.cfg_sy = '0; bus.cfg_alt_sx = '0;
        bus.cfg_en = 1'b0; bus.collect = '0;
        repeat (3) tick();
        chk("rst_is_object", 32'(bus.is_object), 0);
        chk("rst_pixel_addr", 32'(bus.pixel_addr), 0);
        chk("rst_obj_id", 32'(bus.obj_id), 0);
        chk("rst_collected", 32'(bus.collected), 0);
        rst_n = 1'b1;
        tick();

        // Basic hit and exact 2-cycle latency
        cfg(0, 70, 40, 320, 30, 0, 1'b1);
        bus.h_cnt = 10'd150; bus.v_cnt = 10'd84; bus.pix_valid = 1'b1;
        tick();
        chk("lat1_is_object", 32'(bus.is_object), 0);
        tick();
        chk("lat2_is_object", 32'(bus.is_object), 1);
        chk("basic_obj_id", 32'(bus.obj_id), 0);
        chk("basic_addr", 32'(bus.pixel_addr), 11845);

        bus.pix_valid = 1'b0;
        tick(); tick();
        chk("novalid_is_object", 32'(bus.is_object), 0);
        chk("novalid_addr", 32'(bus.pixel_addr), 0);

        // Edges of the 10x10 box at (70,40)
        pix(158, 98, 1'b0);
        chk("edge_in_obj", 32'(bus.is_object), 1);
        chk("edge_in_addr", 32'(bus.pixel_addr), 14369);
        pix(160, 98, 1'b0);
        chk("edge_x_out", 32'(bus.is_object), 0);
        chk("edge_x_out_addr", 32'(bus.pixel_addr), 0);
        pix(158, 100, 1'b0);
        chk("edge_y_out", 32'(bus.is_object), 0);
        pix(138, 84, 1'b0);
        chk("edge_left_out", 32'(bus.is_object), 0);

        // Priority between overlapping slots 0 and 2
        cfg(2, 74, 41, 0, 0, 0, 1'b1);
        pix(150, 84, 1'b0);
        chk("prio_obj_id", 32'(bus.obj_id), 0);
        cfg(0, 70, 40, 320, 30, 0, 1'b0);
        pix(150, 84, 1'b0);
        chk("prio_hide_obj", 32'(bus.is_object), 1);
        chk("prio_hide_id", 32'(bus.obj_id), 2);
        chk("prio_hide_addr", 32'(bus.pixel_addr), 361);

        // Dark-mode alternate sheet origin
        cfg(1, 70, 220, 320, 190, 330, 1'b1);
        pix(140, 440, 1'b1);
        chk("dark_id", 32'(bus.obj_id), 1);
        chk("dark_addr", 32'(bus.pixel_addr), 68730);
        pix(140, 440, 1'b0);
        chk("light_addr", 32'(bus.pixel_addr), 68720);

        // Pickup blink sequence on slot 0
        cfg(2, 74, 41, 0, 0, 0, 1'b0);
        cfg(0, 70, 40, 320, 30, 0, 1'b1);
        pix(150, 84, 1'b0);
        bus.collect = 4'b0001;
        tick();
        bus.collect = 4'b0000;
        tick(); tick();
        chk("blink_k0", 32'(bus.is_object), 1);
        for (int k = 1; k <= 16; k++) begin
            frame();
            chk($sformatf("blink_k%0d", k), 32'(bus.is_object),
                ((k < 16) && (((k >> 1) & 1) == 0)) ? 1 : 0);
        end
        chk("blink_collected", 32'(bus.collected), 32'h1);
        bus.collect = 4'b0001;
        tick();
        bus.collect = 4'b0000;
        tick(); tick();
        chk("done_ignore_collect", 32'(bus.is_object), 0);

        // Reset in the middle of a blink, overriding a same-cycle write
        cfg(0, 70, 40, 320, 30, 0, 1'b1);
        chk("rewrite_clears_col", 32'(bus.collected), 0);
        bus.collect = 4'b0010;
        tick();
        bus.collect = 4'b0000;
        repeat (9) frame();
        bus.collect = 4'b0001;
        tick();
        bus.collect = 4'b0000;
        repeat (7) frame();
        chk("pre_rst_collected", 32'(bus.collected), 32'h2);
        rst_n = 1'b0;
        bus.frame_start = 1'b1;
        bus.collect = 4'b1111;
        bus.cfg_slot = 2'd3; bus.cfg_x = 9'd70; bus.cfg_y = 9'd40; bus.cfg_en = 1'b1;
        bus.cfg_we = 1'b1;
        tick();
        rst_n = 1'b1;
        bus.frame_start = 1'b0;
        bus.collect = 4'b0000;
        bus.cfg_we = 1'b0;
        chk("midrst_is_object", 32'(bus.is_object), 0);
        chk("midrst_addr", 32'(bus.pixel_addr), 0);
        chk("midrst_collected", 32'(bus.collected), 0);
        pix(150, 84, 1'b0);
        chk("midrst_not_drawn", 32'(bus.is_object), 0);

        // Write and collect on the same slot in the same cycle
        bus.cfg_slot = 2'd3; bus.cfg_x = 9'd200; bus.cfg_y = 9'd200;
        bus.cfg_sx = 9'd0; bus.cfg_sy = 9'd0; bus.cfg_alt_sx = 9'd0; bus.cfg_en = 1'b1;
        bus.cfg_we = 1'b1;
        bus.collect = 4'b1000;
        tick();
        bus.cfg_we = 1'b0;
        bus.collect = 4'b0000;
        pix(400, 400, 1'b0);
        chk("race_is_object", 32'(bus.is_object), 1);
        chk("race_obj_id", 32'(bus.obj_id), 3);
        chk("race_addr", 32'(bus.pixel_addr), 0);
        frame();
        frame();
        chk("race_still_shown", 32'(bus.is_object), 1);
        chk("race_collected", 32'(bus.collected), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/obj_renderer.md
OBJ_RENDERER -- requirements
Module: obj_renderer

Interface
REQ-001 Parameter NUM_OBJ, default 4, number of object slots (1..8).
REQ-002 Parameter OBJ_W, default 10, sprite width in scaled pixels.
REQ-003 Parameter OBJ_H, default 10, sprite height in scaled pixels.
REQ-004 Parameter SHEET_W, default 360, sprite-sheet row pitch in words.
REQ-005 Parameter SHEET_DEPTH, default 86400, sprite-sheet size in words.
REQ-006 Parameter BLINK_FRAMES, default 16, frame count of the pickup blink sequence.
REQ-007 Parameter IW = max(1, $clog2(NUM_OBJ)), slot index width (derived).
REQ-008 clk  in  1  single system clock; all logic on its rising edge.
REQ-009 rst_n  in  1  synchronous, active-low reset.
REQ-010 h_cnt  in  10  VGA horizontal count.
REQ-011 v_cnt  in  10  VGA vertical count.
REQ-012 pix_valid  in  1  h_cnt/v_cnt in the visible area.
REQ-013 frame_start  in  1  one-cycle pulse per frame.
REQ-014 is_dark  in  1  selects each slot's alternate (dark) sprite.
REQ-015 cfg_we  in  1  slot configuration write strobe.
REQ-016 cfg_slot  in  IW  slot being written.
REQ-017 cfg_x, cfg_y  in  9 each  top-left screen position (scaled).
REQ-018 cfg_sx, cfg_sy  in  9 each  sprite-sheet origin, light mode.
REQ-019 cfg_alt_sx  in  9  sprite-sheet x origin, dark mode (same sy).
REQ-020 cfg_en  in  1  1 = show slot, 0 = hide slot.
REQ-021 collect  in  NUM_OBJ  per-slot pickup pulse.
REQ-022 pixel_addr  out  17  sprite-sheet read address, registered.
REQ-023 is_object  out  1  an object covers the current pixel, registered.
REQ-024 obj_id  out  IW  index of the covering slot, registered.
REQ-025 collected  out  NUM_OBJ  per-slot pickup-complete flags, registered.

Function
REQ-026 Scaled coordinates SHALL be x = h_cnt>>1, y = v_cnt>>1.
REQ-027 Each slot SHALL hold a state machine with states HIDDEN, SHOWN, BLINK, DONE, plus a blink counter of $clog2(BLINK_FRAMES+1) bits.
REQ-028 cfg_we SHALL load the addressed slot's registers and move it to SHOWN (cfg_en=1) or HIDDEN (cfg_en=0), clear its blink counter and clear its collected bit, from any state.
REQ-029 collect[i] in SHOWN SHALL move slot i to BLINK with counter 0; collect in any other state SHALL be ignored.
REQ-030 In BLINK each frame_start SHALL increment the counter; the frame_start that raises the counter to BLINK_FRAMES SHALL move the slot to DONE and set collected[i].
REQ-031 If cfg_we and collect target the same slot in the same cycle, cfg_we SHALL win.
REQ-032 A slot SHALL be drawable in SHOWN, and in BLINK only while counter bit 1 = 0; never in HIDDEN or DONE.
REQ-033 Slot i SHALL hit when drawable, ox <= x < ox+OBJ_W and oy <= y < oy+OBJ_H, evaluated at full width without overflow.
REQ-034 With multiple hits, the lowest slot index SHALL win.
REQ-035 Address SHALL be ((sy + y - oy)*SHEET_W + sxm + x - ox) mod SHEET_DEPTH, with sxm = cfg_alt_sx if is_dark else cfg_sx, computed at 18+ bits before reduction.
REQ-036 Pipeline latency SHALL be exactly 2 cycles from h_cnt/v_cnt/pix_valid/is_dark to pixel_addr/is_object/obj_id (stage 1: hit detect and offsets; stage 2: priority select and address).
REQ-037 With no hit or pix_valid=0, is_object, pixel_addr and obj_id SHALL be 0 at the output.
REQ-038 Configuration or state changes SHALL affect pixels sampled in the cycle after the write/transition edge.

Reset
REQ-039 While rst_n = 0 at a clock edge, all slots SHALL go HIDDEN, counters 0, slot registers 0, collected 0, pipeline registers and all outputs 0.
REQ-040 Reset SHALL override cfg_we, collect and frame_start in the same cycle, including mid-BLINK.

Verification
REQ-041 Slot 0 cfg x=70,y=40,sx=320,sy=30,en=1; h_cnt=150,v_cnt=84,pix_valid=1 -> 2 cycles later is_object=1, obj_id=0, pixel_addr=11845.
REQ-042 Slots 0 and 2 both cover (75,42) -> obj_id=0; hide slot 0 (cfg_en=0) -> obj_id=2 on the next sampled pixel.
REQ-043 Slot 1 sx=320, alt_sx=330, sy=190, at (70,220); pixel (70,220) with is_dark=1 -> pixel_addr=68730; is_dark=0 -> 68720.
REQ-044 collect[0] then 16 frame_start pulses -> visible after frame_starts 0,1,4,5,8,9,12,13 count, hidden after 2,3,6,7,10,11,14,15; collected[0]=1 and slot not drawn after the 16th.
REQ-045 rst_n=0 for one cycle during BLINK (counter 7) -> next cycle all outputs 0, collected=0, slot not drawn until rewritten.
REQ-046 cfg_we and collect on slot 3 same cycle -> slot 3 SHOWN, counter 0, collected[3]=0.
